// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry circular-buffer pipeline stage with flush and stall.
// Head payload is masked to zero whenever the buffer is empty.
module pipe_stage_buf #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter bit READY_PASS = 1'b1
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // pointers wrap explicitly so non-power-of-2 depths work
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = ~empty & ~stall & ~flush;
    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign in_ready  = ~ARESET & ~stall & ~flush & (~full | (READY_PASS & out_ready));
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wrap_inc(wr_ptr);
            if (pop)
                rd_ptr <= wrap_inc(rd_ptr);
            if (push != pop)
                count <= push ? count + 1'b1 : count - 1'b1;
        end
    end

    // storage is left unreset; the empty mask on out_data hides stale entries
    always_ff @(posedge ACLK) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: three stage configurations share one directed stimulus stream;
// a queue model per instance is compared every cycle, plus hand-computed pins.
module tb_pipe_stage_buf;
    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       flush;
    logic       stall;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       ir  [3];
    logic       ov  [3];
    logic [7:0] od  [3];
    logic [1:0] cnt [3];

    logic [7:0] q [3][$];
    int         dep [3] = '{2, 2, 3};
    bit         rp  [3] = '{1'b0, 1'b1, 1'b1};
    int         total = 0;
    int         bad = 0;

    bit         pin_en = 1'b0;
    int         pin_k;
    string      pin_name;
    int         pin_cnt;
    logic       pin_ov;
    logic       pin_ir;
    logic [7:0] pin_od;

    always #5 ACLK = ~ACLK;

    pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .READY_PASS(1'b0)) u0 (
        .ACLK(ACLK), .ARESET(ARESET), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .count(cnt[0]));
    pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .READY_PASS(1'b1)) u1 (
        .ACLK(ACLK), .ARESET(ARESET), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .count(cnt[1]));
    pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .READY_PASS(1'b1)) u2 (
        .ACLK(ACLK), .ARESET(ARESET), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .count(cnt[2]));

    function automatic logic exp_ir(input int k);
        return !ARESET && !stall && !flush &&
               (q[k].size() < dep[k] || (rp[k] && out_ready && q[k].size() == dep[k]));
    endfunction

    function automatic logic exp_ov(input int k);
        return q[k].size() != 0 && !stall && !flush;
    endfunction

    function automatic logic [7:0] exp_od(input int k);
        return (q[k].size() != 0) ? q[k][0] : 8'h00;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // model: entries held are exactly the accepted-but-not-yet-consumed payloads
    always @(posedge ACLK or posedge ARESET) begin
        logic dp;
        logic dq;
        if (ARESET) begin
            for (int k = 0; k < 3; k++)
                q[k].delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                dp = in_valid && exp_ir(k);
                dq = exp_ov(k) && out_ready;
                if (flush)
                    q[k].delete();
                else begin
                    if (dq)
                        void'(q[k].pop_front());
                    if (dp)
                        q[k].push_back(in_data);
                end
            end
        end
    end

    always @(negedge ACLK) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d count", k), int'(cnt[k]), q[k].size());
            chk($sformatf("u%0d out_valid", k), int'(ov[k]), int'(exp_ov(k)));
            chk($sformatf("u%0d out_data", k), int'(od[k]), int'(exp_od(k)));
            chk($sformatf("u%0d in_ready", k), int'(ir[k]), int'(exp_ir(k)));
        end
        if (pin_en) begin
            chk({pin_name, " count"}, int'(cnt[pin_k]), pin_cnt);
            chk({pin_name, " out_valid"}, int'(ov[pin_k]), int'(pin_ov));
            chk({pin_name, " out_data"}, int'(od[pin_k]), int'(pin_od));
            chk({pin_name, " in_ready"}, int'(ir[pin_k]), int'(pin_ir));
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic drive(input logic fl, input logic st, input logic iv,
                         input logic [7:0] d, input logic ordy);
        flush     = fl;
        stall     = st;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic pin(input int k, input string nm, input int c, input logic v,
                       input logic [7:0] d, input logic r);
        pin_k    = k;
        pin_name = nm;
        pin_cnt  = c;
        pin_ov   = v;
        pin_od   = d;
        pin_ir   = r;
        pin_en   = 1'b1;
    endtask

    task automatic drain();
        repeat (4) begin
            drive(0, 0, 0, 8'h00, 1);
            tick();
        end
    endtask

    initial begin
        int nin;
        int nout;
        int c;
        bit iv;
        bit rd;
        bit r;
        bit p;
        bit o;
        ARESET = 1'b1;
        drive(0, 0, 0, 8'h00, 0);
        pin(0, "reset", 0, 0, 8'h00, 0);
        repeat (2) @(negedge ACLK);
        tick();
        ARESET = 1'b0;

        // fill a depth-2 registered-ready stage, then drain in order
        drive(0, 0, 1, 8'h0A, 0); pin(0, "a_empty", 0, 0, 8'h00, 1); tick();
        drive(0, 0, 1, 8'h0B, 0); pin(0, "a_one", 1, 1, 8'h0A, 1); tick();
        drive(0, 0, 0, 8'h00, 0); pin(0, "a_full", 2, 1, 8'h0A, 0); tick();
        drive(0, 0, 0, 8'h00, 1); pin(0, "a_full_rdy", 2, 1, 8'h0A, 0); tick();
        drive(0, 0, 0, 8'h00, 1); pin(0, "a_pop_b", 1, 1, 8'h0B, 1); tick();
        drive(0, 0, 0, 8'h00, 0); pin(0, "a_empty2", 0, 0, 8'h00, 1); tick();

        // full pass-through stage sustains one transfer per cycle
        drive(0, 0, 1, 8'hE0, 0); tick();
        drive(0, 0, 1, 8'hE1, 0); tick();
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 1, 8'(i), 1);
            pin(1, $sformatf("b_stream%0d", i), 2, 1,
                (i == 1) ? 8'hE0 : (i == 2) ? 8'hE1 : 8'(i - 2), 1);
            tick();
        end
        drain();
        drive(0, 0, 0, 8'h00, 0); pin(1, "b_drained", 0, 0, 8'h00, 1); tick();

        // depth-3 staggered traffic: pointers wrap, order 0..9 preserved
        nin = 0; nout = 0; c = 0;
        for (int t = 0; t < 60 && nout < 10; t++) begin
            iv = (nin < 10) && (t % 4 != 3);
            rd = (t % 3 != 1);
            r  = (c < 3) || (rd && c == 3);
            p  = iv && r;
            o  = rd && c != 0;
            drive(0, 0, iv, 8'(nin), rd);
            pin(2, $sformatf("c_t%0d", t), c, c != 0, (c != 0) ? 8'(nout) : 8'h00, r);
            tick();
            nin  += int'(p);
            nout += int'(o);
            c    += int'(p) - int'(o);
        end
        drive(0, 0, 0, 8'h00, 0); pin(2, "c_done", 0, 0, 8'h00, 1); tick();
        drain();

        // flush beats stall and a concurrent push
        drive(0, 0, 1, 8'h21, 0); tick();
        drive(0, 0, 1, 8'h22, 0); tick();
        drive(1, 1, 1, 8'h33, 1); pin(0, "d_flush", 2, 0, 8'h21, 0); tick();
        drive(0, 0, 0, 8'h00, 0); pin(0, "d_after", 0, 0, 8'h00, 1); tick();
        pin(0, "d_absent", 0, 0, 8'h00, 1); tick();

        // stall freezes a single held entry
        drive(0, 0, 1, 8'h44, 0); tick();
        repeat (3) begin
            drive(0, 1, 1, 8'h55, 1); pin(0, "e_stall", 1, 0, 8'h44, 0); tick();
        end
        drive(0, 0, 0, 8'h00, 1); pin(0, "e_release", 1, 1, 8'h44, 1); tick();
        drive(0, 0, 0, 8'h00, 0); pin(0, "e_popped", 0, 0, 8'h00, 1); tick();

        // asynchronous reset pulse between edges while full
        drive(0, 0, 1, 8'h61, 0); tick();
        drive(0, 0, 1, 8'h62, 0); tick();
        drive(0, 0, 0, 8'h00, 0);
        ARESET = 1'b1;
        pin(0, "f_areset", 0, 0, 8'h00, 0);
        @(negedge ACLK);
        #1;
        ARESET = 1'b0;
        tick();
        drive(0, 0, 1, 8'h05, 0); pin(0, "f_first", 0, 0, 8'h00, 1); tick();
        drive(0, 0, 0, 8'h00, 0); pin(0, "f_latency", 1, 1, 8'h05, 1); tick();
        @(negedge ACLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of storage entries (>=1).
REQ-003 SHALL have parameter READY_PASS, default 1; 1 = in_ready also asserted when full and draining, 0 = in_ready purely registered.
REQ-004 SHALL have port ACLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port ARESET  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  discard all held entries.
REQ-007 SHALL have port stall  input  1  freeze stage: no enqueue, no dequeue.
REQ-008 SHALL have port in_valid  input  1  upstream payload valid.
REQ-009 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-010 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-011 SHALL have port out_valid  output  1  head entry valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts head.
REQ-013 SHALL have port out_data  output  WIDTH  head payload.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  entries held.

Function
REQ-015 SHALL store entries in a DEPTH-entry circular buffer; write/read pointers wrap DEPTH-1 -> 0, including non-power-of-2 DEPTH.
REQ-016 SHALL define push = in_valid & in_ready; pop = out_valid & out_ready; transfer on rising ACLK.
REQ-017 SHALL drive out_valid = (count != 0) & ~stall & ~flush.
REQ-018 SHALL drive out_data = head entry when count != 0, else all-zero (bubble = '0).
REQ-019 SHALL drive in_ready = ~stall & ~flush & ((count < DEPTH) | (READY_PASS & out_ready & count == DEPTH)).
REQ-020 SHALL give one-cycle latency: data pushed at edge N is at out_data after edge N when buffer was empty.
REQ-021 SHALL preserve FIFO order; no entry duplicated or dropped except by flush/reset.
REQ-022 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers; when full with READY_PASS=1, sustain 1 transfer/cycle.
REQ-023 SHALL, on flush high at an edge, set count 0 and both pointers 0; flush overrides push, pop and stall; storage contents need not be cleared.
REQ-024 SHALL, while stall high and flush low, hold count, pointers and storage unchanged regardless of in_valid/out_ready.
REQ-025 SHALL never overflow (push when full without pop impossible by REQ-019) nor underflow (pop when empty impossible by REQ-017).
REQ-026 SHALL have no combinational path in_valid -> in_ready or out_ready -> out_valid; out_ready -> in_ready exists only when READY_PASS=1.

Reset
REQ-027 SHALL, while ARESET high, asynchronously force count 0, pointers 0, out_valid 0, out_data '0, in_ready 0.
REQ-028 SHALL, on reset mid-operation, discard all entries; first push after ARESET deasserts behaves as on an empty buffer.
REQ-029 SHALL not require storage array reset; out_data masking (REQ-018) hides stale contents.

Structure
REQ-030 SHALL keep stage bus typedefs (e.g. ID/EX, EX/MEM bus structs) in the shared pipeline package; instances set WIDTH = $bits(<bus_t>) and cast at the boundary.
REQ-031 SHALL define no new package content; pointer width and count width derived locally from DEPTH.
REQ-032 SHALL be a single module; no sub-module is natural (pointer wrap logic is inline).

Verification
REQ-033 DEPTH=2, push 0xA, 0xB with out_ready=0 -> count=2, in_ready=0 (READY_PASS=0), then out_ready=1 -> out_data 0xA then 0xB, count 0, out_data 0.
REQ-034 DEPTH=2, READY_PASS=1, full, in_valid=out_ready=1 for 8 cycles pushing 0x1..0x8 -> 8 pops in order, count stays 2, in_ready=1 every cycle.
REQ-035 DEPTH=3, push/pop 10 entries staggered -> pointers wrap 2->0, output order 0..9 intact.
REQ-036 DEPTH=2, count=2, assert flush with in_valid=1 and stall=1 -> next cycle count=0, out_valid=0, out_data=0, pushed item absent.
REQ-037 count=1, stall=1 for 3 cycles with in_valid=out_ready=1 -> in_ready=0, out_valid=0, count=1; stall drop -> head entry pops unchanged.
REQ-038 count=2, pulse ARESET between edges -> count, out_valid, out_data 0 immediately; push 0x5 after release -> out_data 0x5 next cycle.
